// File: rtl/shift_result_stage_if.sv
// Valid/ready bundle between the barrel shifter and the registered result stage.
// The master side is the producer/consumer environment; the slave side is the stage.
interface shift_result_stage_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    // Upstream command and shifter result
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_din;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_mode;
    logic [WIDTH-1:0] in_dout;

    // Downstream result and status
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_err;
    logic [15:0]      err_count;

    modport master (
        output in_valid, in_din, in_shamt, in_mode, in_dout, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, out_carry,
               out_err, err_count
    );

    modport slave (
        input  in_valid, in_din, in_shamt, in_mode, in_dout, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, out_carry,
               out_err, err_count
    );
endinterface

// File: rtl/shift_result_stage.sv
// Registered output stage for the multi-mode barrel shifter.
// Captures the shifter result, derives zero/neg/carry/illegal-mode flags at
// capture time, and presents them through a two-entry skid buffer so that the
// upstream ready is a flop and full throughput survives backpressure.
module shift_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_result_stage_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        MODE_SHL  = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_ASHL = 3'd2,
        MODE_ASHR = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5
    } mode_e;

    // One buffered result with the flags that travel alongside it
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             err;
    } entry_t;

    mode_e          w_mode;
    entry_t         w_new;
    logic [SHW-1:0] w_left_idx;
    logic [SHW-1:0] w_right_idx;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_skid_load;

    entry_t         r_out;
    entry_t         r_skid;
    logic           r_out_valid;
    logic           r_skid_valid;
    logic           r_in_ready;
    logic [15:0]    r_err_count;

    assign w_mode      = mode_e'(bus.in_mode);
    assign w_in_fire   = bus.in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & bus.out_ready;
    // The only way in while the output is stalled is into the skid slot.
    assign w_skid_load = w_in_fire & r_out_valid & ~bus.out_ready;

    // Build the entry (result plus flags) from the current shifter command
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case below can leave it unassigned and infer a latch.
        w_new       = '0;
        // WIDTH is a power of two, so WIDTH-shamt is just -shamt modulo WIDTH.
        w_left_idx  = -bus.in_shamt;
        w_right_idx = bus.in_shamt - SHW'(1);

        w_new.err  = (bus.in_mode > 3'd5);
        w_new.data = w_new.err ? bus.in_din : bus.in_dout;

        // A zero shift moves nothing out; illegal modes never report a carry.
        if (!w_new.err && (bus.in_shamt != '0)) begin
            case (w_mode)
                MODE_SHL, MODE_ASHL: w_new.carry = bus.in_din[w_left_idx];
                MODE_SHR, MODE_ASHR: w_new.carry = bus.in_din[w_right_idx];
                MODE_ROTL:           w_new.carry = w_new.data[0];
                MODE_ROTR:           w_new.carry = w_new.data[WIDTH-1];
                default:             w_new.carry = 1'b0;
            endcase
        end

        w_new.zero = (w_new.data == '0);
        w_new.neg  = w_new.data[WIDTH-1];
    end

    // Output register, skid occupancy and registered upstream ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid || w_out_fire) begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch sees the pre-edge values of the other registers.
            if (r_skid_valid) begin
                // in_ready is low here, so no new input competes with the skid.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_out       <= w_new;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    // Skid payload; only meaningful while r_skid_valid is set
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately not reset; its valid bit is, and
        // nothing reads the payload while that bit is clear.
        if (w_skid_load) begin
            r_skid <= w_new;
        end
    end

    // Saturating count of accepted illegal-mode commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_in_fire && w_new.err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out.data;
    assign bus.out_zero  = r_out.zero;
    assign bus.out_neg   = r_out.neg;
    assign bus.out_carry = r_out.carry;
    assign bus.out_err   = r_out.err;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_shift_result_stage.sv
// Directed bench for shift_result_stage: flag derivation per mode, illegal
// mode handling and counter saturation, skid-buffer ordering under
// backpressure, and asynchronous reset while entries are held.
module tb_shift_result_stage;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_result_stage_if #(.WIDTH(WIDTH)) bus ();

    shift_result_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] data,
                             input logic zero, input logic neg,
                             input logic carry, input logic err);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".data"},  bus.out_data, data);
        check({tag, ".zero"},  {31'd0, bus.out_zero},  {31'd0, zero});
        check({tag, ".neg"},   {31'd0, bus.out_neg},   {31'd0, neg});
        check({tag, ".carry"}, {31'd0, bus.out_carry}, {31'd0, carry});
        check({tag, ".err"},   {31'd0, bus.out_err},   {31'd0, err});
    endtask

    task automatic drive(input logic valid, input logic [31:0] din,
                         input logic [4:0] shamt, input logic [2:0] mode,
                         input logic [31:0] dout);
        bus.in_valid = valid;
        bus.in_din   = din;
        bus.in_shamt = shamt;
        bus.in_mode  = mode;
        bus.in_dout  = dout;
    endtask

    // Inputs change and outputs are sampled on the falling edge only.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 3'd0, 32'h0);

        // Reset state
        step();
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst.data",      bus.out_data, 32'h0);
        check("rst.flags", {28'd0, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_err}, 32'd0);
        check("rst.err_count", {16'd0, bus.err_count}, 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back commands, out_ready=1: one result per cycle, 1-cycle latency
        drive(1'b1, 32'hF000_0001, 5'd4, 3'd0, 32'h0000_0010);
        step();
        check_out("shl", 32'h0000_0010, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(1'b1, 32'h0000_0003, 5'd2, 3'd1, 32'h0000_0000);
        step();
        check_out("shr", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        drive(1'b1, 32'h0000_0003, 5'd0, 3'd1, 32'h0000_0003);
        step();
        check_out("shr0", 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 32'h8000_0000, 5'd1, 3'd4, 32'h0000_0001);
        step();
        check_out("rotl", 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(1'b1, 32'h0000_0001, 5'd1, 3'd5, 32'h8000_0000);
        step();
        check_out("rotr", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(1'b1, 32'h4000_0000, 5'd2, 3'd2, 32'h0000_0000);
        step();
        check_out("ashl", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        drive(1'b1, 32'h8000_0004, 5'd3, 3'd3, 32'hF000_0000);
        step();
        check_out("ashr", 32'hF000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(1'b1, 32'h0000_0002, 5'd31, 3'd0, 32'h0000_0000);
        step();
        check_out("shl31", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("legal.err_count", {16'd0, bus.err_count}, 32'd0);

        // Illegal modes: result forced to din, no carry even with a nonzero shift
        drive(1'b1, 32'h1234_5678, 5'd4, 3'd6, 32'hDEAD_BEEF);
        step();
        check_out("mode6", 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mode6.err_count", {16'd0, bus.err_count}, 32'd1);

        drive(1'b1, 32'h8000_0000, 5'd1, 3'd7, 32'h0000_0001);
        step();
        check_out("mode7", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mode7.err_count", {16'd0, bus.err_count}, 32'd2);

        drive(1'b1, 32'h0000_0000, 5'd0, 3'd6, 32'hFFFF_FFFF);
        step();
        check_out("mode6z", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mode6z.err_count", {16'd0, bus.err_count}, 32'd3);

        // Saturation: 3 already counted, 65531 more reach 0xFFFE, then keep pushing
        repeat (65531) step();
        check("sat.fffe", {16'd0, bus.err_count}, 32'h0000_FFFE);
        step();
        check("sat.ffff", {16'd0, bus.err_count}, 32'h0000_FFFF);
        repeat (4466) step();
        check("sat.hold", {16'd0, bus.err_count}, 32'h0000_FFFF);

        drive(1'b0, 32'h0, 5'd0, 3'd0, 32'h0);
        step();
        check("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: A, B, C offered back to back while out_ready=0
        bus.out_ready = 1'b0;
        check("bp.ready0", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'h0000_0005, 5'd1, 3'd1, 32'h0000_0002);          // A
        step();
        check_out("bp.a_cap", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp.ready_a", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'hC000_0000, 5'd1, 3'd2, 32'h8000_0000);          // B
        step();
        check("bp.ready_b", {31'd0, bus.in_ready}, 32'd0);
        check_out("bp.a_hold1", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0003, 5'd4, 3'd4, 32'h0000_0030);          // C
        step();
        check("bp.ready_c1", {31'd0, bus.in_ready}, 32'd0);
        check_out("bp.a_hold2", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("bp.ready_c2", {31'd0, bus.in_ready}, 32'd0);
        check_out("bp.a_hold3", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);

        // Release: A leaves, B from skid, then C straight into the output
        bus.out_ready = 1'b1;
        step();
        check_out("bp.b", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check("bp.ready_rise", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_out("bp.c", 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 3'd0, 32'h0);
        step();
        check("bp.drained", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset while both entries are occupied
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0011, 5'd1, 3'd0, 32'h0000_0022);
        step();
        drive(1'b1, 32'h0000_0033, 5'd1, 3'd0, 32'h0000_0066);
        step();
        drive(1'b0, 32'h0, 5'd0, 3'd0, 32'h0);
        check("ar.pre_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ar.pre_ready", {31'd0, bus.in_ready},  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar.in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("ar.err_count", {16'd0, bus.err_count}, 32'd0);
        check("ar.data",      bus.out_data, 32'h0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ar.no_stale%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Normal operation resumes after reset
        drive(1'b1, 32'h0000_0001, 5'd1, 3'd5, 32'h8000_0000);
        step();
        check_out("ar.resume", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 3'd0, 32'h0);
        step();
        check("ar.resume_done", {31'd0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
